axil_cfg_sequencer: RTL and testbench

AXI4-Lite master that programs and optionally verifies the 4-register start_signal slave (or any AXI4-Lite slave with contiguous 32-bit registers). On a start pulse it writes C_NUM_REGS words to consecutive word addresses from C_BASE_ADDR. It can then read every register back and compare it with the written value, and it reports done or error. It replaces the test-bench VIP master in the real design and sits between the control logic and the start_signal S00_AXI port.

---
 rtl/axil_cfg_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_axil_cfg_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master that programs a block of contiguous 32-bit registers and
// optionally reads them back to verify, reporting done/error to the control logic.
module axil_cfg_sequencer #(
  parameter int unsigned                          C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                          C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                          C_NUM_REGS         = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]        C_BASE_ADDR        = '0,
  parameter int unsigned                          C_TIMEOUT          = 255
) (
  input  logic                                    ACLK,
  input  logic                                    ARESETN,
  input  logic                                    start,
  input  logic                                    verify_en,
  input  logic [C_M_AXI_DATA_WIDTH*C_NUM_REGS-1:0] cfg_data,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    error,
  output logic [1:0]                              err_code,
  output logic [3:0]                              err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic [2:0]                              M_AXI_AWPROT,
  output logic                                    M_AXI_AWVALID,
  input  logic                                    M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
  output logic                                    M_AXI_WVALID,
  input  logic                                    M_AXI_WREADY,
  input  logic [1:0]                              M_AXI_BRESP,
  input  logic                                    M_AXI_BVALID,
  output logic                                    M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic [2:0]                              M_AXI_ARPROT,
  output logic                                    M_AXI_ARVALID,
  input  logic                                    M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                              M_AXI_RRESP,
  input  logic                                    M_AXI_RVALID,
  output logic                                    M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam int unsigned TW = $clog2(C_TIMEOUT + 1);

  localparam logic [3:0]    LAST_IDX = 4'(C_NUM_REGS - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(C_TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RESP    = 2'd1;
  localparam logic [1:0] ERR_DATA    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_FINISH
  } state_t;

  state_t                       state;
  logic [3:0]                   idx;
  logic [TW-1:0]                tcnt;
  logic [C_NUM_REGS-1:0][DW-1:0] snap;
  logic                         verify_q;
  logic                         aw_done;
  logic                         w_done;

  logic          aw_fin_c, w_fin_c, b_hs_c, ar_hs_c, r_hs_c;
  logic          waiting_c, progress_c, abort_c, last_c;
  logic [1:0]    abort_code_c;
  logic [DW-1:0] exp_word_c;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  assign aw_fin_c   = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_fin_c    = w_done  | (M_AXI_WVALID  & M_AXI_WREADY);
  assign b_hs_c     = M_AXI_BVALID & M_AXI_BREADY;
  assign ar_hs_c    = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs_c     = M_AXI_RVALID & M_AXI_RREADY;
  assign exp_word_c = snap[IW'(idx)];
  assign last_c     = (idx == LAST_IDX);

  function automatic logic [AW-1:0] reg_addr(input logic [3:0] i);
    return C_BASE_ADDR + AW'({i, 2'b00});
  endfunction

  // Per-state progress and abort detection; priority: bad response, data mismatch, timeout
  always_comb begin
    waiting_c    = 1'b0;
    progress_c   = 1'b0;
    abort_code_c = ERR_NONE;
    unique case (state)
      S_WR_REQ:  begin waiting_c = 1'b1; progress_c = aw_fin_c & w_fin_c; end
      S_WR_RESP: begin waiting_c = 1'b1; progress_c = b_hs_c;             end
      S_RD_REQ:  begin waiting_c = 1'b1; progress_c = ar_hs_c;            end
      S_RD_RESP: begin waiting_c = 1'b1; progress_c = r_hs_c;             end
      default:   ;
    endcase
    if (state == S_WR_RESP && b_hs_c && M_AXI_BRESP != 2'b00)
      abort_code_c = ERR_RESP;
    else if (state == S_RD_RESP && r_hs_c && M_AXI_RRESP != 2'b00)
      abort_code_c = ERR_RESP;
    else if (state == S_RD_RESP && r_hs_c && M_AXI_RDATA != exp_word_c)
      abort_code_c = ERR_DATA;
    else if (waiting_c && !progress_c && tcnt == T_LAST)
      abort_code_c = ERR_TIMEOUT;
    abort_c = (abort_code_c != ERR_NONE);
  end

  // Sequencer FSM with registered AXI and status outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      idx           <= '0;
      tcnt          <= '0;
      snap          <= '0;
      verify_q      <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      err_idx       <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_c) begin
        error         <= 1'b1;
        err_code      <= abort_code_c;
        err_idx       <= idx;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        busy          <= 1'b0;
        done          <= 1'b1;
        state         <= S_FINISH;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            snap     <= cfg_data;
            verify_q <= verify_en;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            err_idx  <= '0;
            idx      <= '0;
            tcnt     <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            busy     <= 1'b1;
            state    <= S_WR_REQ;
          end
          // VALIDs rise one cycle after entry and each falls after its own handshake
          S_WR_REQ: begin
            M_AXI_AWADDR <= reg_addr(idx);
            M_AXI_WDATA  <= exp_word_c;
            if (progress_c) begin
              M_AXI_AWVALID <= 1'b0;
              M_AXI_WVALID  <= 1'b0;
              M_AXI_BREADY  <= 1'b1;
              tcnt          <= '0;
              state         <= S_WR_RESP;
            end else begin
              M_AXI_AWVALID <= !aw_fin_c;
              M_AXI_WVALID  <= !w_fin_c;
              aw_done       <= aw_fin_c;
              w_done        <= w_fin_c;
              tcnt          <= tcnt + 1'b1;
            end
          end
          S_WR_RESP: begin
            if (progress_c) begin
              M_AXI_BREADY <= 1'b0;
              tcnt         <= '0;
              if (!last_c) begin
                idx     <= idx + 1'b1;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                state   <= S_WR_REQ;
              end else if (verify_q) begin
                idx   <= '0;
                state <= S_RD_REQ;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_FINISH;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_RD_REQ: begin
            M_AXI_ARADDR <= reg_addr(idx);
            if (progress_c) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              tcnt          <= '0;
              state         <= S_RD_RESP;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              tcnt          <= tcnt + 1'b1;
            end
          end
          S_RD_RESP: begin
            if (progress_c) begin
              M_AXI_RREADY <= 1'b0;
              tcnt         <= '0;
              if (!last_c) begin
                idx   <= idx + 1'b1;
                state <= S_RD_REQ;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_FINISH;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_FINISH: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Randomized bench for axil_cfg_sequencer: reactive AXI4-Lite slave with stall and
// fault injection, checked against a transaction-level model of the sequence.
module tb_axil_cfg_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned TMO  = 255;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic            start = 1'b0;
  logic            verify_en = 1'b0;
  logic [32*N-1:0] cfg_data = '0;
  logic            busy, done, error;
  logic [1:0]      err_code;
  logic [3:0]      err_idx;
  logic [31:0]     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]      M_AXI_WSTRB;
  logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic            M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;

  axil_cfg_sequencer #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_NUM_REGS(N),
    .C_BASE_ADDR(BASE),
    .C_TIMEOUT(TMO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .verify_en(verify_en),
    .cfg_data(cfg_data), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .err_idx(err_idx),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Slave configuration and state
  int          aw_delay = 0, w_delay = 0, bad_bresp_idx = -1, bad_rdata_idx = -1;
  int          aw_cnt, w_cnt;
  logic        aw_have, w_have, slv_clr = 1'b0;
  logic [31:0] aw_addr_q, w_data_q, cur_aw_addr, cur_w_data;
  logic        aw_hs, w_hs;
  logic [31:0] mem [N];
  logic [31:0] wr_addr_log[$], wr_data_log[$], rd_addr_log[$];

  function automatic int reg_of(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'(N - 1));
  endfunction

  assign M_AXI_AWREADY = !aw_have && (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = !w_have && (w_cnt >= w_delay);
  assign M_AXI_ARREADY = !M_AXI_RVALID;
  assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;
  assign cur_aw_addr   = aw_hs ? M_AXI_AWADDR : aw_addr_q;
  assign cur_w_data    = w_hs ? M_AXI_WDATA : w_data_q;

  // Slave: B issued the edge both AW and W are complete, R the edge after AR
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN || slv_clr) begin
      aw_cnt <= 0; w_cnt <= 0; aw_have <= 1'b0; w_have <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
    end else begin
      if (aw_hs) begin aw_addr_q <= M_AXI_AWADDR; aw_cnt <= 0; end
      else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_data_q <= M_AXI_WDATA; w_cnt <= 0; end
      else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;
      if ((aw_have || aw_hs) && (w_have || w_hs)) begin
        M_AXI_BVALID <= 1'b1;
        M_AXI_BRESP  <= (reg_of(cur_aw_addr) == bad_bresp_idx) ? 2'b10 : 2'b00;
        mem[reg_of(cur_aw_addr)] <= cur_w_data;
        wr_addr_log.push_back(cur_aw_addr);
        wr_data_log.push_back(cur_w_data);
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end else begin
        if (aw_hs) aw_have <= 1'b1;
        if (w_hs)  w_have  <= 1'b1;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RRESP  <= 2'b00;
        M_AXI_RDATA  <= (reg_of(M_AXI_ARADDR) == bad_rdata_idx) ? 32'h0000_DEAD
                                                                : mem[reg_of(M_AXI_ARADDR)];
        rd_addr_log.push_back(M_AXI_ARADDR);
      end else if (M_AXI_RVALID && M_AXI_RREADY) begin
        M_AXI_RVALID <= 1'b0;
      end
    end
  end

  int    n_tests = 0, n_fail = 0;
  string cur_name = "reset";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0h expected %0h", cur_name, tag, got, exp);
    end
  endtask

  // Transaction-level expectation of one sequence
  logic [31:0] words [N];
  logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
  bit          exp_err;
  int          exp_code, exp_idx, exp_lat;

  task automatic build_expect(input bit ver, input int ad, input int wd, input int bb, input int br);
    int stall;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    exp_err = 0; exp_code = 0; exp_idx = 0; exp_lat = 1;
    stall = (ad > wd) ? ad : wd;
    if (stall >= int'(TMO)) begin
      exp_err = 1; exp_code = 3; exp_lat = int'(TMO) + 1;
      return;
    end
    for (int i = 0; i < int'(N); i++) begin
      exp_lat += 3 + stall;
      exp_wa.push_back(BASE + 32'(4 * i));
      exp_wd.push_back(words[i]);
      if (i == bb) begin exp_err = 1; exp_code = 1; exp_idx = i; return; end
    end
    if (!ver) return;
    for (int i = 0; i < int'(N); i++) begin
      exp_lat += 3;
      exp_ra.push_back(BASE + 32'(4 * i));
      if (i == br && words[i] != 32'h0000_DEAD) begin
        exp_err = 1; exp_code = 2; exp_idx = i; return;
      end
    end
  endtask

  task automatic run_seq(input string name, input bit ver, input int ad, input int wd,
                         input int bb, input int br, input bit poke);
    int t0;
    cur_name = name;
    @(negedge ACLK);
    slv_clr = 1'b1;
    aw_delay = ad; w_delay = wd; bad_bresp_idx = bb; bad_rdata_idx = br;
    @(negedge ACLK);
    slv_clr = 1'b0;
    wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
    build_expect(ver, ad, wd, bb, br);
    for (int i = 0; i < int'(N); i++) cfg_data[32*i +: 32] = words[i];
    verify_en = ver;
    start = 1'b1;
    t0 = cyc;
    @(negedge ACLK);
    start = 1'b0;
    cfg_data = {$urandom, $urandom, $urandom, $urandom};
    verify_en = 1'($urandom);
    while (!done && (cyc - t0) < 600) begin
      start = poke && (cyc - t0 == 5);
      @(negedge ACLK);
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", cyc - t0, exp_lat);
    check("busy_at_done", busy, 0);
    check("error", error, exp_err);
    check("err_code", err_code, exp_code);
    check("err_idx", err_idx, exp_idx);
    check("axi_idle_at_done",
          {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    check("wr_count", wr_addr_log.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < wr_addr_log.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wr_addr_log[i], exp_wa[i]);
      check($sformatf("wr_data%0d", i), wr_data_log[i], exp_wd[i]);
    end
    check("rd_count", rd_addr_log.size(), exp_ra.size());
    for (int i = 0; i < exp_ra.size() && i < rd_addr_log.size(); i++)
      check($sformatf("rd_addr%0d", i), rd_addr_log[i], exp_ra[i]);
    // A start landing on the done cycle must not launch a new sequence
    start = poke;
    @(negedge ACLK);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_after_finish", busy, 0);
    @(negedge ACLK);
    check("no_late_start", busy, 0);
  endtask

  initial begin
    int hit;
    repeat (3) @(negedge ACLK);
    check("rst_status", {busy, done, error, err_code, err_idx}, 0);
    check("rst_axi", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    check("wstrb", M_AXI_WSTRB, 4'hF);
    check("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3; words[3] = 32'd4;
    run_seq("zero_wait_verify", 1'b1, 0, 0, -1, -1, 1'b0);
    run_seq("w_before_aw", 1'b1, 3, 0, -1, -1, 1'b0);
    run_seq("aw_before_w", 1'b1, 0, 3, -1, -1, 1'b0);
    run_seq("bresp_err_r2", 1'b1, 0, 0, 2, -1, 1'b0);
    run_seq("rdata_bad_r1", 1'b1, 0, 0, -1, 1, 1'b0);
    run_seq("awready_stall", 1'b1, 300, 0, -1, -1, 1'b0);
    run_seq("write_only", 1'b0, 1, 0, -1, -1, 1'b1);

    // Asynchronous reset while waiting for B of register 1
    cur_name = "reset_mid_seq";
    for (int i = 0; i < int'(N); i++) begin
      words[i] = $urandom;
      cfg_data[32*i +: 32] = words[i];
    end
    verify_en = 1'b1;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    hit = 0;
    for (int k = 0; k < 60 && hit == 0; k++) begin
      @(negedge ACLK);
      if (M_AXI_BREADY && M_AXI_AWADDR == BASE + 32'd4) hit = 1;
    end
    check("reached_wr_resp1", hit, 1);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_status", {busy, done, error, err_code, err_idx}, 0);
    check("mid_rst_axi", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    run_seq("after_reset", 1'b1, 0, 0, -1, -1, 1'b1);

    for (int t = 0; t < 12; t++) begin
      int ad, wd, bb, br;
      for (int i = 0; i < int'(N); i++) words[i] = $urandom;
      ad = int'($urandom_range(0, 4));
      wd = int'($urandom_range(0, 4));
      bb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      br = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_seq($sformatf("rand%0d", t), 1'($urandom_range(0, 3) != 0), ad, wd, bb, br,
              1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
